// File: rtl/axi_resp_sched_if.sv
// rtl/axi_resp_sched_if.sv - response FIFO heads plus AXI B/R channel bundle
// master is the scheduler side; slave is the FIFO/AXI-master environment.
interface axi_resp_sched_if #(
    parameter int ID_W   = 8,
    parameter int DATA_W = 64
) ();
    logic              rdata_r_en;
    logic [DATA_W-1:0] axi_rdata;
    logic              rdata_fifo_empty;
    logic              resp_r_en;
    logic [1:0]        axi_resp;
    logic              resp_fifo_empty;
    logic              id_resp_r_en;
    logic [ID_W+1:0]   axi_id_resp;
    logic              id_resp_fifo_empty;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output rdata_r_en, resp_r_en, id_resp_r_en,
        input  axi_rdata, rdata_fifo_empty, axi_resp, resp_fifo_empty,
        input  axi_id_resp, id_resp_fifo_empty,
        output bid, bresp, bvalid,
        input  bready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport slave (
        input  rdata_r_en, resp_r_en, id_resp_r_en,
        output axi_rdata, rdata_fifo_empty, axi_resp, resp_fifo_empty,
        output axi_id_resp, id_resp_fifo_empty,
        input  bid, bresp, bvalid,
        output bready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_resp_sched.sv
// rtl/axi_resp_sched.sv - drains shared response FIFOs into independent AXI B and R output registers
// Tracks read bursts for ID interleave errors and flags channels held past STALL_MAX.
module axi_resp_sched #(
    parameter int ID_W      = 8,
    parameter int DATA_W    = 64,
    parameter int STALL_MAX = 1024
) (
    input  logic                aclk,
    input  logic                areset,
    axi_resp_sched_if.master    bus,
    output logic                burst_err,
    output logic                stall_err,
    output logic [15:0]         drop_cnt
);
    localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);

    typedef enum logic {IDLE, RBURST} state_t;

    state_t            state;
    logic [ID_W-1:0]   burst_id;
    logic [15:0]       b_stall;
    logic [15:0]       r_stall;

    logic              is_write;
    logic              vbit;
    logic [ID_W-1:0]   head_id;
    logic              head_ok;
    logic              b_free;
    logic              r_free;
    logic              pop;
    logic              pop_b;
    logic              pop_drop;
    logic              pop_r;

    assign is_write = bus.axi_id_resp[ID_W+1];
    assign vbit     = bus.axi_id_resp[ID_W];
    assign head_id  = bus.axi_id_resp[ID_W-1:0];
    assign head_ok  = !bus.rdata_fifo_empty && !bus.resp_fifo_empty && !bus.id_resp_fifo_empty;
    assign b_free   = !bus.bvalid || bus.bready;
    assign r_free   = !bus.rvalid || bus.rready;

    // The three FIFOs advance in lock-step, so one strobe serves them all.
    always_comb begin
        pop      = head_ok && !areset && (is_write ? b_free : r_free);
        pop_b    = pop && is_write && vbit;
        pop_drop = pop && is_write && !vbit;
        pop_r    = pop && !is_write;
    end

    assign bus.rdata_r_en   = pop;
    assign bus.resp_r_en    = pop;
    assign bus.id_resp_r_en = pop;

    always_ff @(posedge aclk) begin
        if (areset) begin
            bus.bvalid <= 1'b0;
            bus.bid    <= '0;
            bus.bresp  <= '0;
            bus.rvalid <= 1'b0;
            bus.rid    <= '0;
            bus.rdata  <= '0;
            bus.rresp  <= '0;
            bus.rlast  <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (pop_b) begin
                bus.bvalid <= 1'b1;
                bus.bid    <= head_id;
                bus.bresp  <= bus.axi_resp;
            end else if (bus.bready) begin
                bus.bvalid <= 1'b0;
            end
            if (pop_r) begin
                bus.rvalid <= 1'b1;
                bus.rid    <= head_id;
                bus.rdata  <= bus.axi_rdata;
                bus.rresp  <= bus.axi_resp;
                bus.rlast  <= vbit;
            end else if (bus.rready) begin
                bus.rvalid <= 1'b0;
            end
            if (pop_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Write entries pass through without disturbing the read-burst tracking.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            burst_id  <= '0;
            burst_err <= 1'b0;
        end else if (pop_r) begin
            if (state == RBURST && head_id != burst_id) begin
                burst_err <= 1'b1;
            end
            burst_id <= head_id;
            state    <= vbit ? IDLE : RBURST;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            b_stall   <= '0;
            r_stall   <= '0;
            stall_err <= 1'b0;
        end else begin
            if (bus.bvalid && !bus.bready) begin
                if (b_stall != STALL_LIM) begin
                    b_stall <= b_stall + 16'd1;
                end
                if (b_stall == STALL_LIM - 16'd1) begin
                    stall_err <= 1'b1;
                end
            end else begin
                b_stall <= '0;
            end
            if (bus.rvalid && !bus.rready) begin
                if (r_stall != STALL_LIM) begin
                    r_stall <= r_stall + 16'd1;
                end
                if (r_stall == STALL_LIM - 16'd1) begin
                    stall_err <= 1'b1;
                end
            end else begin
                r_stall <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axi_resp_sched.sv
// tb/tb_axi_resp_sched.sv - randomized and directed bench for axi_resp_sched
// A queue-based FIFO model plus per-channel beat slots predicts every cycle.
module tb_axi_resp_sched;
    localparam int ID_W   = 8;
    localparam int DATA_W = 64;
    localparam int SMAX   = 8;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_resp_sched_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus ();
    logic        burst_err;
    logic        stall_err;
    logic [15:0] drop_cnt;

    axi_resp_sched #(.ID_W(ID_W), .DATA_W(DATA_W), .STALL_MAX(SMAX)) dut (
        .aclk(aclk), .areset(areset), .bus(bus),
        .burst_err(burst_err), .stall_err(stall_err), .drop_cnt(drop_cnt)
    );

    typedef struct {
        bit          w;
        bit          v;
        logic [7:0]  id;
        logic [1:0]  resp;
        logic [63:0] data;
    } entry_t;

    entry_t fifo[$];
    int total = 0;
    int bad = 0;

    bit          m_bv, m_rv, m_rlast, m_in_burst, m_burst_err, m_stall_err;
    logic [7:0]  m_bid, m_rid, m_burst_id;
    logic [1:0]  m_bresp, m_rresp;
    logic [63:0] m_rdata;
    int          m_drop, m_bs, m_rs;

    task automatic push(input bit w, input bit v, input logic [7:0] id,
                        input logic [1:0] resp, input logic [63:0] data);
        entry_t e;
        e.w = w; e.v = v; e.id = id; e.resp = resp; e.data = data;
        fifo.push_back(e);
    endtask

    task automatic drive_heads(input logic [2:0] fe);
        logic e;
        e = (fifo.size() == 0);
        if (!e) begin
            bus.axi_id_resp = {fifo[0].w, fifo[0].v, fifo[0].id};
            bus.axi_resp    = fifo[0].resp;
            bus.axi_rdata   = fifo[0].data;
        end else begin
            bus.axi_id_resp = 10'($urandom);
            bus.axi_resp    = 2'($urandom);
            bus.axi_rdata   = {$urandom, $urandom};
        end
        bus.rdata_fifo_empty   = e | fe[0];
        bus.resp_fifo_empty    = e | fe[1];
        bus.id_resp_fifo_empty = e | fe[2];
    endtask

    // One clock: drive at negedge, predict, check strobes, advance, check registered outputs.
    task automatic step(input bit br, input bit rr, input logic [2:0] fe);
        bit p;
        entry_t h;
        drive_heads(fe);
        bus.bready = br;
        bus.rready = rr;
        #1;
        p = (fifo.size() > 0) && (fe == 3'b000) && (fifo[0].w ? (!m_bv || br) : (!m_rv || rr));
        total++;
        if (bus.rdata_r_en !== p || bus.resp_r_en !== p || bus.id_resp_r_en !== p) begin
            bad++;
            $display("FAIL pop_strobe: got %b%b%b want %b", bus.rdata_r_en, bus.resp_r_en, bus.id_resp_r_en, p);
        end
        if (m_bv && !br) begin
            if (m_bs < SMAX) m_bs++;
            if (m_bs == SMAX) m_stall_err = 1;
        end else m_bs = 0;
        if (m_rv && !rr) begin
            if (m_rs < SMAX) m_rs++;
            if (m_rs == SMAX) m_stall_err = 1;
        end else m_rs = 0;
        if (p) h = fifo.pop_front();
        if (p && h.w && h.v) begin
            m_bv = 1; m_bid = h.id; m_bresp = h.resp;
        end else if (br) m_bv = 0;
        if (p && h.w && !h.v && m_drop < 65535) m_drop++;
        if (p && !h.w) begin
            m_rv = 1; m_rid = h.id; m_rdata = h.data; m_rresp = h.resp; m_rlast = h.v;
            if (m_in_burst && h.id != m_burst_id) m_burst_err = 1;
            m_burst_id = h.id;
            m_in_burst = !h.v;
        end else if (rr) m_rv = 0;
        @(posedge aclk);
        @(negedge aclk);
        total++;
        if (bus.bvalid !== m_bv || (m_bv && (bus.bid !== m_bid || bus.bresp !== m_bresp))) begin
            bad++;
            $display("FAIL b_chan: got v=%b id=%h resp=%h want v=%b id=%h resp=%h",
                     bus.bvalid, bus.bid, bus.bresp, m_bv, m_bid, m_bresp);
        end
        total++;
        if (bus.rvalid !== m_rv || (m_rv && (bus.rid !== m_rid || bus.rdata !== m_rdata ||
            bus.rresp !== m_rresp || bus.rlast !== m_rlast))) begin
            bad++;
            $display("FAIL r_chan: got v=%b id=%h d=%h resp=%h last=%b want v=%b id=%h d=%h resp=%h last=%b",
                     bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast,
                     m_rv, m_rid, m_rdata, m_rresp, m_rlast);
        end
        total++;
        if (burst_err !== m_burst_err || stall_err !== m_stall_err || drop_cnt !== 16'(m_drop)) begin
            bad++;
            $display("FAIL flags: got burst=%b stall=%b drop=%0d want burst=%b stall=%b drop=%0d",
                     burst_err, stall_err, drop_cnt, m_burst_err, m_stall_err, m_drop);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        drive_heads(3'b000);
        bus.bready = 1'($urandom);
        bus.rready = 1'($urandom);
        #1;
        total++;
        if (fifo.size() > 0 && (bus.rdata_r_en !== 1'b0 || bus.resp_r_en !== 1'b0 || bus.id_resp_r_en !== 1'b0)) begin
            bad++;
            $display("FAIL reset_strobe: got %b%b%b want 000", bus.rdata_r_en, bus.resp_r_en, bus.id_resp_r_en);
        end
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        m_bv = 0; m_rv = 0; m_rlast = 0; m_in_burst = 0; m_burst_err = 0; m_stall_err = 0;
        m_bid = 0; m_rid = 0; m_burst_id = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
        m_drop = 0; m_bs = 0; m_rs = 0;
        total++;
        if (bus.bvalid !== 0 || bus.bid !== 0 || bus.bresp !== 0 || bus.rvalid !== 0 || bus.rid !== 0 ||
            bus.rdata !== 0 || bus.rresp !== 0 || bus.rlast !== 0 || burst_err !== 0 ||
            stall_err !== 0 || drop_cnt !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got bv=%b rv=%b bid=%h rid=%h rdata=%h burst=%b stall=%b drop=%0d want all zero",
                     bus.bvalid, bus.rvalid, bus.bid, bus.rid, bus.rdata, burst_err, stall_err, drop_cnt);
        end
    endtask

    task automatic test_single_write();
        push(1, 1, 8'h12, 2'b00, 64'h0);
        step(1, 1, 3'b000);
        total++;
        if (bus.bvalid !== 1'b1 || bus.bid !== 8'h12 || bus.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL write_cycle1: got bv=%b bid=%h rv=%b want 1 12 0", bus.bvalid, bus.bid, bus.rvalid);
        end
        step(1, 1, 3'b000);
        total++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL write_cycle2: got bv=%b rv=%b want 0 0", bus.bvalid, bus.rvalid);
        end
    endtask

    task automatic test_read_burst();
        for (int i = 0; i < 4; i++) push(0, i == 3, 8'h05, 2'b00, 64'(i));
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 3'b000);
            total++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== 64'(i) || bus.rlast !== (i == 3)) begin
                bad++;
                $display("FAIL burst_beat%0d: got rv=%b d=%0d last=%b want 1 %0d %b",
                         i, bus.rvalid, bus.rdata, bus.rlast, i, i == 3);
            end
        end
        step(1, 1, 3'b000);
        push(0, 0, 8'h07, 2'b01, 64'd99);
        push(0, 1, 8'h07, 2'b00, 64'd100);
        repeat (3) step(1, 1, 3'b000);
        total++;
        if (bus.rvalid !== 1'b0 || burst_err !== 1'b0) begin
            bad++;
            $display("FAIL burst_idle: got rv=%b burst_err=%b want 0 0", bus.rvalid, burst_err);
        end
    endtask

    task automatic test_independence();
        push(0, 1, 8'h09, 2'b10, 64'hABCD);
        push(1, 1, 8'h21, 2'b01, 64'h0);
        step(1, 0, 3'b000);
        step(1, 0, 3'b000);
        total++;
        if (bus.bvalid !== 1'b1 || bus.bid !== 8'h21 || bus.rvalid !== 1'b1 || bus.rdata !== 64'hABCD) begin
            bad++;
            $display("FAIL indep_b_pass: got bv=%b bid=%h rv=%b rdata=%h want 1 21 1 abcd",
                     bus.bvalid, bus.bid, bus.rvalid, bus.rdata);
        end
        push(0, 1, 8'h0A, 2'b00, 64'h55);
        step(1, 0, 3'b000);
        step(1, 0, 3'b000);
        total++;
        if (bus.rdata !== 64'hABCD || bus.rid !== 8'h09 || bus.bvalid !== 1'b0) begin
            bad++;
            $display("FAIL indep_hold: got rdata=%h rid=%h bv=%b want abcd 09 0", bus.rdata, bus.rid, bus.bvalid);
        end
        step(1, 1, 3'b000);
        total++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 64'h55 || bus.rid !== 8'h0A) begin
            bad++;
            $display("FAIL indep_release: got rv=%b rdata=%h rid=%h want 1 55 0a", bus.rvalid, bus.rdata, bus.rid);
        end
        step(1, 1, 3'b000);
    endtask

    task automatic test_drop();
        push(1, 0, 8'h44, 2'b00, 64'h0);
        push(1, 1, 8'h33, 2'b00, 64'h0);
        step(1, 1, 3'b000);
        total++;
        if (bus.bvalid !== 1'b0 || drop_cnt !== 16'd1) begin
            bad++;
            $display("FAIL drop_null: got bv=%b drop=%0d want 0 1", bus.bvalid, drop_cnt);
        end
        step(1, 1, 3'b000);
        total++;
        if (bus.bvalid !== 1'b1 || bus.bid !== 8'h33) begin
            bad++;
            $display("FAIL drop_next: got bv=%b bid=%h want 1 33", bus.bvalid, bus.bid);
        end
        step(1, 1, 3'b000);
    endtask

    task automatic test_partial_empty();
        logic [2:0] masks [6];
        masks = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110};
        push(1, 1, 8'h66, 2'b11, 64'h0);
        foreach (masks[k]) step(1, 1, masks[k]);
        total++;
        if (bus.bvalid !== 1'b0) begin
            bad++;
            $display("FAIL partial_nopop: got bv=%b want 0", bus.bvalid);
        end
        step(1, 1, 3'b000);
        step(1, 1, 3'b000);
    endtask

    task automatic test_burst_err();
        int beats;
        beats = 0;
        push(0, 0, 8'h01, 2'b00, 64'h1);
        push(0, 0, 8'h02, 2'b00, 64'h2);
        push(0, 1, 8'h02, 2'b00, 64'h3);
        step(1, 1, 3'b000);
        if (bus.rvalid === 1'b1) beats++;
        total++;
        if (burst_err !== 1'b0) begin
            bad++;
            $display("FAIL burst_err_early: got %b want 0", burst_err);
        end
        step(1, 1, 3'b000);
        if (bus.rvalid === 1'b1) beats++;
        total++;
        if (burst_err !== 1'b1) begin
            bad++;
            $display("FAIL burst_err_set: got %b want 1", burst_err);
        end
        step(1, 1, 3'b000);
        if (bus.rvalid === 1'b1) beats++;
        step(1, 1, 3'b000);
        if (bus.rvalid === 1'b1) beats++;
        total++;
        if (beats != 3) begin
            bad++;
            $display("FAIL burst_err_beats: got %0d want 3", beats);
        end
    endtask

    task automatic test_random();
        int cycles;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 2) == 0)
                push(1, $urandom_range(0, 4) != 0, 8'($urandom), 2'($urandom), 64'h0);
            else
                push(0, $urandom_range(0, 2) == 0, 8'($urandom_range(1, 3)), 2'($urandom),
                     {$urandom, $urandom});
        end
        cycles = 0;
        while ((fifo.size() > 0 || m_bv || m_rv) && cycles < 3000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
            cycles++;
        end
        total++;
        if (cycles >= 3000) begin
            bad++;
            $display("FAIL random_timeout: got %0d cycles, %0d entries left want drained", cycles, fifo.size());
        end
    endtask

    task automatic test_stall();
        fifo.delete();
        test_reset();
        push(1, 1, 8'h77, 2'b11, 64'h0);
        step(0, 0, 3'b000);
        for (int i = 0; i < 7; i++) step(0, 0, 3'b000);
        total++;
        if (stall_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_early: got %b want 0", stall_err);
        end
        step(0, 0, 3'b000);
        total++;
        if (stall_err !== 1'b1 || bus.bvalid !== 1'b1 || bus.bid !== 8'h77) begin
            bad++;
            $display("FAIL stall_set: got stall=%b bv=%b bid=%h want 1 1 77", stall_err, bus.bvalid, bus.bid);
        end
        push(1, 1, 8'h78, 2'b00, 64'h0);
        test_reset();
        step(1, 1, 3'b000);
        total++;
        if (bus.bvalid !== 1'b1 || bus.bid !== 8'h78 || stall_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_after_reset: got bv=%b bid=%h stall=%b want 1 78 0", bus.bvalid, bus.bid, stall_err);
        end
        step(1, 1, 3'b000);
    endtask

    initial begin
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        drive_heads(3'b000);
        repeat (2) @(negedge aclk);
        push(0, 1, 8'h01, 2'b00, 64'h1);
        test_reset();
        fifo.delete();
        test_single_write();
        test_read_burst();
        test_independence();
        test_drop();
        test_partial_empty();
        test_burst_err();
        test_random();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
